// File: rtl/io_input_conditioner.sv
// io_input_conditioner: synchronise, debounce and polarity-normalise board switches and buttons.
// Drives the debounced {buttons, switches} bus plus registered press and switch-change pulses.
module io_input_conditioner #(
    parameter int SW_WIDTH        = 10,
    parameter int BTN_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit BTN_ACTIVE_LOW  = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [SW_WIDTH-1:0]           sw_raw,
    input  logic [BTN_WIDTH-1:0]          btn_raw,
    output logic [SW_WIDTH+BTN_WIDTH-1:0] io_input_bus,
    output logic [BTN_WIDTH-1:0]          btn_press,
    output logic                          sw_changed
);
    localparam int W = SW_WIDTH + BTN_WIDTH;
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [W-1:0] n, s1, s2, stable, stable_d;
    logic [CW-1:0] cnt [W];
    assign n = {BTN_ACTIVE_LOW ? ~btn_raw : btn_raw, sw_raw};
    assign io_input_bus = stable;
    // stable_d lags stable by one edge so the event pulses land one cycle after the bus changes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1         <= '0;
            s2         <= '0;
            stable     <= '0;
            stable_d   <= '0;
            btn_press  <= '0;
            sw_changed <= 1'b0;
            for (int i = 0; i < W; i++) cnt[i] <= '0;
        end else begin
            s1         <= n;
            s2         <= s1;
            stable_d   <= stable;
            btn_press  <= stable[W-1:SW_WIDTH] & ~stable_d[W-1:SW_WIDTH];
            sw_changed <= |(stable[SW_WIDTH-1:0] ^ stable_d[SW_WIDTH-1:0]);
            for (int i = 0; i < W; i++) begin
                cnt[i] <= (s2[i] == stable[i] || cnt[i] == LAST) ? '0 : cnt[i] + CW'(1);
                if (s2[i] != stable[i] && cnt[i] == LAST) stable[i] <= s2[i];
            end
        end
    end
endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner: scoreboard bench for io_input_conditioner with DEBOUNCE_CYCLES=4.
// The reference model accepts a level once it has been seen unchanged for D consecutive synchronised samples.
module tb_io_input_conditioner;
    localparam int D = 4;
    logic        clock;
    logic        reset;
    logic [9:0]  sw_raw;
    logic [3:0]  btn_raw;
    logic [13:0] io_input_bus;
    logic [3:0]  btn_press;
    logic        sw_changed;
    int vectors = 0;
    int miscompares = 0;
    logic [18:0] exp_q [$];
    logic [13:0] hist [$];
    logic [13:0] m_stab, m_stab_d;
    logic [3:0]  m_press;
    logic        m_chg;

    io_input_conditioner #(
        .SW_WIDTH(10), .BTN_WIDTH(4), .DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1)
    ) dut (
        .clock(clock), .reset(reset), .sw_raw(sw_raw), .btn_raw(btn_raw),
        .io_input_bus(io_input_bus), .btn_press(btn_press), .sw_changed(sw_changed)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and push what the outputs must be after the next rising edge.
    task automatic step(input logic r, input logic [9:0] sw, input logic [3:0] btn);
        logic [13:0] nv;
        @(negedge clock);
        reset = r;
        sw_raw = sw;
        btn_raw = btn;
        nv = {~btn, sw};
        if (!r) begin
            m_stab = '0;
            m_stab_d = '0;
            m_press = '0;
            m_chg = 1'b0;
            hist.delete();
            repeat (D + 2) hist.push_back('0);
        end else begin
            m_press = m_stab[13:10] & ~m_stab_d[13:10];
            m_chg = |(m_stab[9:0] ^ m_stab_d[9:0]);
            m_stab_d = m_stab;
            hist.push_back(nv);
            for (int b = 0; b < 14; b++) begin
                logic flip;
                flip = 1'b1;
                for (int j = hist.size() - D - 2; j <= hist.size() - 3; j++)
                    if (hist[j][b] == m_stab[b]) flip = 1'b0;
                if (flip) m_stab[b] = ~m_stab[b];
            end
            while (hist.size() > D + 2) void'(hist.pop_front());
        end
        exp_q.push_back({m_stab, m_press, m_chg});
    endtask

    initial begin
        logic [18:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("io_input_bus", io_input_bus, e[18:5]);
                check("btn_press", {10'd0, btn_press}, {10'd0, e[4:1]});
                check("sw_changed", {13'd0, sw_changed}, {13'd0, e[0]});
            end
        end
    end

    initial begin
        logic [9:0] rs;
        logic [3:0] rb;
        int k;
        reset = 0;
        sw_raw = '0;
        btn_raw = 4'hF;
        // everything held active through reset, then debounces in together
        repeat (3) step(0, 10'h3FF, 4'h0);
        #1 check("reset_bus", io_input_bus, 14'h0);
        check("reset_press", {10'd0, btn_press}, 14'h0);
        repeat (6) step(1, 10'h3FF, 4'h0);
        #1 check("bus_before_E5", io_input_bus, 14'h0);
        step(1, 10'h3FF, 4'h0);
        #1 check("bus_at_E5", io_input_bus, 14'h3FFF);
        step(1, 10'h3FF, 4'h0);
        #1 check("press_all", {10'd0, btn_press}, 14'h000F);
        check("sw_changed_all", {13'd0, sw_changed}, 14'h1);
        step(1, 10'h3FF, 4'h0);
        #1 check("press_cleared", {10'd0, btn_press}, 14'h0);
        check("sw_changed_cleared", {13'd0, sw_changed}, 14'h0);
        // back to idle
        repeat (10) step(1, 10'h000, 4'hF);
        // clean switch change
        repeat (10) step(1, 10'h008, 4'hF);
        // glitch on button 1: 3 cycles pressed rejected, 5 cycles accepted
        repeat (3) step(1, 10'h008, 4'b1101);
        repeat (8) step(1, 10'h008, 4'hF);
        repeat (5) step(1, 10'h008, 4'b1101);
        repeat (10) step(1, 10'h008, 4'hF);
        // bounce on switch 0 then settle high
        for (int c = 0; c < 20; c++) step(1, {9'h004, c[1]}, 4'hF);
        repeat (10) step(1, 10'h009, 4'hF);
        // buttons 0 and 3 pressed, then released together; switches 2 and 7 together
        repeat (8) step(1, 10'h009, 4'b0110);
        repeat (8) step(1, 10'h009, 4'hF);
        repeat (8) step(1, 10'h08D, 4'hF);
        // reset while button 2's counter is mid-count
        repeat (4) step(1, 10'h08D, 4'b1011);
        step(0, 10'h08D, 4'b1011);
        #1 check("midreset_bus", io_input_bus, 14'h0);
        repeat (2) step(0, 10'h08D, 4'b1011);
        repeat (10) step(1, 10'h08D, 4'b1011);
        // random traffic with slow toggling and occasional reset
        rs = '0;
        rb = 4'hF;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 4) == 0) begin
                k = $urandom_range(0, 13);
                if (k < 10) rs[k] = ~rs[k];
                else rb[k-10] = ~rb[k-10];
            end
            step($urandom_range(0, 149) != 0, rs, rb);
        end
        repeat (2) @(negedge clock);
        check("queue_drained", 14'(exp_q.size()), 14'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Conditions the raw board inputs (10 slide switches, 4 push-buttons) before they reach the data memory's IO read block. Each input is synchronised to `clock`, debounced with a per-bit counter, and polarity-normalised, then driven as the 14-bit `io_input_bus` that data_memory maps to IO read addresses. One-cycle press pulses and a switch-change pulse are also provided for future interrupt or event logic.

## Interface
Parameters:
- `SW_WIDTH`, 10: number of slide switches; maps to io_input_bus[9:0].
- `BTN_WIDTH`, 4: number of push-buttons; maps to io_input_bus[13:10].
- `DEBOUNCE_CYCLES`, 500000: stable cycles required before an output changes (10 ms at 50 MHz); legal range ≥1.
- `BTN_ACTIVE_LOW`, 1: buttons read 0 when pressed; inverted before synchronisation.

Ports:
- `clock`  in  1  system clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `sw_raw`  in  SW_WIDTH  unsynchronised switch levels.
- `btn_raw`  in  BTN_WIDTH  unsynchronised button levels.
- `io_input_bus`  out  SW_WIDTH+BTN_WIDTH  debounced levels: {buttons, switches}; a button reads 1 while pressed.
- `btn_press`  out  BTN_WIDTH  one-cycle pulse per button on a debounced 0→1 transition.
- `sw_changed`  out  1  one-cycle pulse when any debounced switch bit changes.

## Operation
- Normalise: `n[i]` = raw bit, inverted for buttons when BTN_ACTIVE_LOW=1. This is combinational, ahead of the first flop.
- Synchronise: two flops per bit, `s1` then `s2`.
- Debounce: one counter per bit, width $clog2(DEBOUNCE_CYCLES) (minimum 1), and one `stable` flop per bit.
  - `s2 == stable`: counter is set to 0.
  - `s2 != stable` and counter < DEBOUNCE_CYCLES-1: counter increments.
  - `s2 != stable` and counter == DEBOUNCE_CYCLES-1: `stable` takes `s2` and the counter is set to 0.
- Glitch handling: a mismatch shorter than DEBOUNCE_CYCLES consecutive cycles never reaches `stable`. Its counter restarts from 0 on the first matching cycle.
- Output mapping: `io_input_bus` = {stable_btn, stable_sw}, driven directly from flops with no combinational path from the raw inputs.
- `btn_press[i]` is registered. It is 1 for exactly the cycle after `stable_btn[i]` goes 0→1 and 0 otherwise. A release (1→0) produces no pulse.
- `sw_changed` is registered. It is 1 for one cycle after any `stable_sw` bit changes. Several bits changing on the same edge still give a single one-cycle pulse.
- Bits are fully independent. Simultaneous events on different bits are each handled on their own schedule.

## Timing
- Reset value of every flop, set asynchronously while `reset`=0: `s1`, `s2`, `stable` and counters all 0. Resulting outputs: `io_input_bus`=0, `btn_press`=0, `sw_changed`=0. A held switch or button therefore debounces in after reset like any other change.
- Reset deassertion is not required to be synchronised inside this block; the top level supplies a synchronised release.
- Reset mid-debounce discards the partial count. No pulse is generated on reset entry or exit, except that a held input debounces in and then pulses normally.
- Latency, with raw stable and set up before edge E0:
  - `s1` at E0, `s2` at E1.
  - `stable` and `io_input_bus` change at edge E(DEBOUNCE_CYCLES+1).
  - `btn_press` / `sw_changed` are high during the cycle after E(DEBOUNCE_CYCLES+2).
- DEBOUNCE_CYCLES=1: `stable` follows `s2` one edge later (E2), with no filtering beyond synchronisation.
- Counter wrap-around is impossible: the counter never exceeds DEBOUNCE_CYCLES-1.

## Test plan
- Reset: hold `reset`=0 with `sw_raw`=10'h3FF and `btn_raw`=4'h0 (all pressed). All outputs must read 0 during reset. After release with DEBOUNCE_CYCLES=4, `io_input_bus` = 14'h3FFF at edge E5; `btn_press`=4'hF and `sw_changed`=1 for exactly one cycle after that.
- Clean switch change, DEBOUNCE_CYCLES=4: `sw_raw[3]` 0→1 before E0 -> `io_input_bus[3]`=1 after E5, not before. `sw_changed` is one cycle wide.
- Glitch rejection, DEBOUNCE_CYCLES=4: `btn_raw[1]` low for 3 cycles, then high -> `io_input_bus[11]` stays 0 and `btn_press` stays 0. A subsequent 5-cycle-low pulse is accepted and gives `btn_press`=4'b0010 for one cycle.
- Bounce: `sw_raw[0]` toggles every 2 cycles for 20 cycles, then settles at 1 -> exactly one 0→1 transition on `io_input_bus[0]`, DEBOUNCE_CYCLES+2 edges after settling.
- Release and simultaneity: buttons 0 and 3 released on the same cycle -> both bus bits clear on the same edge and `btn_press` stays 0. Switches 2 and 7 changing together -> a single one-cycle `sw_changed`.
- Reset mid-operation: assert `reset` while the `btn_raw[2]` counter is at 2 -> immediate zero outputs. After release, with the input still held, a full DEBOUNCE_CYCLES+2 latency elapses before `io_input_bus[12]`=1.
